// File: rtl/pixel_stream_assembler.sv
// pixel_stream_assembler
// Packs MCU bus data bytes into PIXEL_WIDTH-bit pixels and queues them in a
// FIFO_DEPTH-entry FIFO. The head pixel is delivered over a valid/ready handshake.
// Every output is driven from a flop, so no combinational path runs from byte_* to pixel_*.
//
// Optional feature: define PIXEL_STREAM_ASSEMBLER_COUNTER_EN to add the pixel_count output.
//
// Ports:
//   system_clock    : sole clock; all state changes on the rising edge
//   reset_n         : asynchronous active-low reset
//   byte_valid      : byte_data / byte_is_command are valid this cycle
//   byte_data       : incoming bus byte
//   byte_is_command : 1 = command byte (restarts assembly), 0 = pixel data byte
//   enable          : 0 = data bytes are ignored
//   pixel_valid     : FIFO head is valid
//   pixel_data      : FIFO head pixel
//   pixel_ready     : consumer accepts the head pixel
//   fifo_level      : current FIFO occupancy, 0..FIFO_DEPTH
//   partial         : a pixel is part-way through assembly
//   overflow        : sticky; a pixel was dropped because the FIFO was full
//   clear_overflow  : clears overflow (a new overflow in the same cycle wins)
//   pixel_count     : (optional) pixels written to the FIFO, wraps at 16 bits
module pixel_stream_assembler #(
  parameter int unsigned PIXEL_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          system_clock,
  input  logic                          reset_n,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_is_command,
  input  logic                          enable,
  output logic                          pixel_valid,
  output logic [PIXEL_WIDTH-1:0]        pixel_data,
  input  logic                          pixel_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          partial,
  output logic                          overflow,
  input  logic                          clear_overflow
`ifdef PIXEL_STREAM_ASSEMBLER_COUNTER_EN
  ,output logic [15:0]                  pixel_count
`endif
);

  localparam int unsigned BPP     = (PIXEL_WIDTH + 7) / 8;
  localparam int unsigned R       = PIXEL_WIDTH - 8 * (BPP - 1);
  localparam int unsigned PHASE_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;

  logic [PHASE_W-1:0]     phase, phase_next;
  logic [PIXEL_WIDTH-1:0] assembly, assembly_next;
  logic [PIXEL_WIDTH-1:0] new_pixel, head_next;
  logic [PIXEL_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_ptr_next;
  logic [LW-1:0]          level_next;
  logic                   data_acc, cmd_acc, last_byte;
  logic                   wr_req, wr_en, pop, full, drop;

  // Byte assembly, FIFO control and next-state computation
  always_comb begin
    data_acc      = byte_valid & ~byte_is_command & enable;
    cmd_acc       = byte_valid & byte_is_command;
    last_byte     = (phase == PHASE_W'(BPP - 1));
    phase_next    = phase;
    assembly_next = assembly;
    wr_req        = 1'b0;
    // The low R bits of the assembly register are never written by earlier
    // bytes, so the last byte supplies them directly.
    new_pixel          = assembly;
    new_pixel[R-1:0]   = byte_data[R-1:0];

    if (cmd_acc) begin
      phase_next    = '0;
      assembly_next = '0;
    end else if (data_acc) begin
      if (last_byte) begin
        wr_req     = 1'b1;
        phase_next = '0;
      end else begin
        phase_next = phase + PHASE_W'(1);
        for (int k = 0; k < int'(BPP) - 1; k++) begin
          if (phase == PHASE_W'(k))
            assembly_next[PIXEL_WIDTH-1-8*k -: 8] = byte_data;
        end
      end
    end

    pop         = pixel_valid & pixel_ready;
    full        = (fifo_level == LW'(FIFO_DEPTH));
    wr_en       = wr_req & (~full | pop);
    drop        = wr_req & full & ~pop;
    level_next  = fifo_level + LW'(wr_en) - LW'(pop);
    rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
    // The new head is the incoming pixel when it lands in the slot the read
    // pointer will point to; otherwise it is already in the array.
    head_next   = (wr_en && (wr_ptr == rd_ptr_next)) ? new_pixel : mem[rd_ptr_next];
  end

  // Control and output registers
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      phase       <= '0;
      assembly    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      partial     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      phase       <= phase_next;
      assembly    <= assembly_next;
      rd_ptr      <= rd_ptr_next;
      fifo_level  <= level_next;
      pixel_valid <= (level_next != '0);
      partial     <= (phase_next != '0);
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (level_next != '0)
        pixel_data <= head_next;
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  // Pixel storage; contents are don't-care until written
  always_ff @(posedge system_clock) begin
    if (wr_en)
      mem[wr_ptr] <= new_pixel;
  end

`ifdef PIXEL_STREAM_ASSEMBLER_COUNTER_EN
  // Count of pixels accepted into the FIFO; any command byte restarts it
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n)
      pixel_count <= '0;
    else if (cmd_acc)
      pixel_count <= '0;
    else if (wr_en)
      pixel_count <= pixel_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_stream_assembler.sv
// Directed self-checking bench for pixel_stream_assembler (default, 20-bit and 6-bit instances).
module tb_pixel_stream_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid, byte_is_command, enable, pixel_ready, clear_overflow;
  logic [7:0]  byte_data;

  logic        pv, pv20, pv6;
  logic [11:0] pd;
  logic [19:0] pd20;
  logic [5:0]  pd6;
  logic [3:0]  lvl, lvl20, lvl6;
  logic        part, part20, part6;
  logic        ovf, ovf20, ovf6;
`ifdef PIXEL_STREAM_ASSEMBLER_COUNTER_EN
  logic [15:0] cnt, cnt20, cnt6;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pixel_stream_assembler u_dut (
    .system_clock(clk), .reset_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_command(byte_is_command), .enable(enable), .pixel_valid(pv), .pixel_data(pd),
    .pixel_ready(pixel_ready), .fifo_level(lvl), .partial(part), .overflow(ovf),
    .clear_overflow(clear_overflow)
`ifdef PIXEL_STREAM_ASSEMBLER_COUNTER_EN
    , .pixel_count(cnt)
`endif
  );

  pixel_stream_assembler #(.PIXEL_WIDTH(20)) u_w20 (
    .system_clock(clk), .reset_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_command(byte_is_command), .enable(enable), .pixel_valid(pv20), .pixel_data(pd20),
    .pixel_ready(pixel_ready), .fifo_level(lvl20), .partial(part20), .overflow(ovf20),
    .clear_overflow(clear_overflow)
`ifdef PIXEL_STREAM_ASSEMBLER_COUNTER_EN
    , .pixel_count(cnt20)
`endif
  );

  pixel_stream_assembler #(.PIXEL_WIDTH(6)) u_w6 (
    .system_clock(clk), .reset_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_is_command(byte_is_command), .enable(enable), .pixel_valid(pv6), .pixel_data(pd6),
    .pixel_ready(pixel_ready), .fifo_level(lvl6), .partial(part6), .overflow(ovf6),
    .clear_overflow(clear_overflow)
`ifdef PIXEL_STREAM_ASSEMBLER_COUNTER_EN
    , .pixel_count(cnt6)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic cmd);
    byte_valid      = 1'b1;
    byte_data       = d;
    byte_is_command = cmd;
    tick();
    byte_valid      = 1'b0;
    byte_is_command = 1'b0;
  endtask

  // Pixel i of the 12-bit FIFO tests: bytes (i+1) and (0xF0|i) -> {i+1, i[3:0]}
  function automatic logic [11:0] pat(input int i);
    return 12'(((i + 1) << 4) | (i & 15));
  endfunction

  task automatic send_pat(input int i);
    send(8'(i + 1), 1'b0);
    send(8'hF0 | 8'(i & 15), 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_is_command = 1'b0;
    enable = 1'b1; pixel_ready = 1'b0; clear_overflow = 1'b0;
    #1;
    check("reset_valid", 32'(pv), 32'd0);
    check("reset_data", 32'(pd), 32'd0);
    check("reset_level", 32'(lvl), 32'd0);
    check("reset_partial", 32'(part), 32'd0);
    check("reset_overflow", 32'(ovf), 32'd0);
    #11;
    rst_n = 1'b1;
    tick();

    // Basic two-byte pixel
    send(8'hAB, 1'b0);
    check("ab_partial", 32'(part), 32'd1);
    check("ab_valid", 32'(pv), 32'd0);
    send(8'hCD, 1'b0);
    check("abcd_valid", 32'(pv), 32'd1);
    check("abcd_data", 32'(pd), 32'hABD);
    check("abcd_level", 32'(lvl), 32'd1);
    check("abcd_partial", 32'(part), 32'd0);
    pixel_ready = 1'b1;
    tick();
    pixel_ready = 1'b0;
    check("pop_valid", 32'(pv), 32'd0);
    check("pop_level", 32'(lvl), 32'd0);

    // Command byte discards partial pixel
    send(8'hAB, 1'b0);
    check("cmd_pre_partial", 32'(part), 32'd1);
    send(8'h55, 1'b1);
    check("cmd_partial", 32'(part), 32'd0);
    check("cmd_valid", 32'(pv), 32'd0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    check("cmd_pix_data", 32'(pd), 32'h124);
    check("cmd_pix_level", 32'(lvl), 32'd1);
    pixel_ready = 1'b1;
    tick();
    pixel_ready = 1'b0;

    // enable=0 drops data bytes
    enable = 1'b0;
    send(8'hAB, 1'b0);
    check("dis_partial", 32'(part), 32'd0);
    check("dis_level", 32'(lvl), 32'd0);
    enable = 1'b1;

    // Overflow: 9 pixels into depth 8; clear_overflow coincides with the drop
    for (int i = 0; i < 8; i++) send_pat(i);
    check("full_level", 32'(lvl), 32'd8);
    check("full_no_ovf", 32'(ovf), 32'd0);
    send(8'(9), 1'b0);
    clear_overflow = 1'b1;
    send(8'hF8, 1'b0);
    clear_overflow = 1'b0;
    check("ovf_level", 32'(lvl), 32'd8);
    check("ovf_set_wins", 32'(ovf), 32'd1);
    check("ovf_partial", 32'(part), 32'd0);
    pixel_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(pv), 32'd1);
      check("drain_data", 32'(pd), 32'(pat(i)));
      tick();
    end
    pixel_ready = 1'b0;
    check("drained_level", 32'(lvl), 32'd0);
    check("drained_valid", 32'(pv), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Full FIFO with simultaneous pop and write
    for (int i = 0; i < 8; i++) send_pat(i);
    send(8'(9), 1'b0);
    pixel_ready = 1'b1;
    send(8'hF8, 1'b0);
    check("fullpop_level", 32'(lvl), 32'd8);
    check("fullpop_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i < 9; i++) begin
      check("fullpop_data", 32'(pd), 32'(pat(i)));
      tick();
    end
    check("fullpop_empty", 32'(lvl), 32'd0);

    // Write on empty with ready high: no fall-through
    send(8'hAB, 1'b0);
    check("nft_pre_valid", 32'(pv), 32'd0);
    send(8'hCD, 1'b0);
    check("nft_valid", 32'(pv), 32'd1);
    check("nft_data", 32'(pd), 32'hABD);
    check("nft_level", 32'(lvl), 32'd1);
    tick();
    check("nft_popped", 32'(lvl), 32'd0);
    pixel_ready = 1'b0;

    // Reset mid-pixel with 3 entries queued
    for (int i = 0; i < 3; i++) send_pat(i);
    send(8'h77, 1'b0);
    check("mid_level", 32'(lvl), 32'd3);
    check("mid_partial", 32'(part), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(pv), 32'd0);
    check("mid_rst_data", 32'(pd), 32'd0);
    check("mid_rst_level", 32'(lvl), 32'd0);
    check("mid_rst_partial", 32'(part), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check("post_rst_data", 32'(pd), 32'h012);
    check("post_rst_level", 32'(lvl), 32'd1);

    // 20-bit instance: three bytes, last byte's upper nibble discarded
    pulse_reset();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    check("w20_partial", 32'(part20), 32'd1);
    check("w20_pre_valid", 32'(pv20), 32'd0);
    send(8'hF5, 1'b0);
    check("w20_valid", 32'(pv20), 32'd1);
    check("w20_data", 32'(pd20), 32'h12345);
    check("w20_level", 32'(lvl20), 32'd1);

    // 6-bit instance: every byte is a pixel
    pulse_reset();
    send(8'hFF, 1'b0);
    check("w6_valid", 32'(pv6), 32'd1);
    check("w6_data", 32'(pd6), 32'h3F);
    check("w6_partial", 32'(part6), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
